// File: rtl/bin_to_bcd_pkg.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   state_t     : converter FSM states (IDLE, SHIFT, DONE)
//   DIGIT_W     : bits per BCD digit
//   ADJ_THRESH  : digit value at or above which the add-3 correction applies
//   ADJ_ADD     : correction constant
//   digits_fit(): elaboration-time check that DIGITS decimal digits can hold
//                 every WIDTH-bit unsigned value
// ---------------------------------------------------------------------------
package bin_to_bcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   localparam int unsigned DIGIT_W    = 4;
   localparam logic [3:0]  ADJ_THRESH = 4'd5;
   localparam logic [3:0]  ADJ_ADD    = 4'd3;

   // True when 10^d > 2^w - 1.
   function automatic bit digits_fit(input int unsigned w, input int unsigned d);
      logic [127:0] pow10;
      logic [127:0] maxval;
      pow10  = 128'd1;
      maxval = (128'd1 << w) - 128'd1;
      for (int unsigned i = 0; i < d; i++) begin
         pow10 = pow10 * 128'd10;
      end
      return pow10 > maxval;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj
// Combinational double-dabble correction cell for one BCD digit: adds 3 when
// the digit is 5 or more, otherwise passes it through. Inputs stay in 0..9,
// so the result never exceeds 12 and fits in 4 bits.
// Ports:
//   din  : 4-bit BCD digit before correction
//   dout : 4-bit digit after correction
// ---------------------------------------------------------------------------
module bcd_digit_adj
   import bin_to_bcd_pkg::*;
(
   input  logic [3:0] din,
   output logic [3:0] dout
);

   assign dout = (din >= ADJ_THRESH) ? din + ADJ_ADD : din;

endmodule

// File: rtl/bin_to_bcd.sv
// ---------------------------------------------------------------------------
// bin_to_bcd
// Sequential shift-and-add-3 (double-dabble) binary-to-BCD converter, one
// binary bit per clock. A conversion takes WIDTH+1 cycles from the accepting
// edge to the done pulse; back-to-back conversions run every WIDTH+2 cycles.
//
// Parameters:
//   WIDTH  : binary input width (default 16)
//   DIGITS : BCD digits produced (default 5); needs 10^DIGITS > 2^WIDTH-1
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   start   : conversion request, sampled only in IDLE
//   bin_in  : unsigned value, captured on the edge that accepts start
//   busy    : high while a conversion is in flight, including the done cycle
//   done    : one-cycle pulse when bcd_out/blank update
//   bcd_out : packed BCD result, digit i at [4i+3:4i], held until next result
//   blank   : leading-zero mask for display gating
//
// Optional feature macro: BIN_TO_BCD_LEADING_ZERO_BLANK_EN
//   defined   : blank[i]=1 (i>=1) when digit i and all higher digits are zero;
//               blank[0] is always 0; registered with bcd_out
//   undefined : blank is tied to 0
// ---------------------------------------------------------------------------
module bin_to_bcd
   import bin_to_bcd_pkg::*;
#(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned DIGITS = 5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [WIDTH-1:0]            bin_in,
   output logic                        busy,
   output logic                        done,
   output logic [DIGIT_W*DIGITS-1:0]   bcd_out,
   output logic [DIGITS-1:0]           blank
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam int unsigned SW = DIGIT_W * DIGITS;

   if (!digits_fit(WIDTH, DIGITS)) begin : g_bad_params
      $error("bin_to_bcd: DIGITS too small to represent every WIDTH-bit value");
   end

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   cnt;
   logic [WIDTH-1:0] sreg;
   logic [SW-1:0]   scratch;
   logic [SW-1:0]   scratch_adj;
   logic            unused_adj_msb;

   // Correction happens combinationally ahead of each shift.
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .din  (scratch[DIGIT_W*g +: DIGIT_W]),
         .dout (scratch_adj[DIGIT_W*g +: DIGIT_W])
      );
   end

   // The top bit of the corrected scratch is shifted out and always zero.
   assign unused_adj_msb = scratch_adj[SW-1];

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (cnt == CW'(1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // -------------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         sreg    <= '0;
         scratch <= '0;
         bcd_out <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sreg    <= bin_in;
                  scratch <= '0;
                  cnt     <= CW'(WIDTH);
               end
            end
            SHIFT: begin
               {scratch, sreg} <= {scratch_adj[SW-2:0], sreg, 1'b0};
               cnt             <= cnt - 1'b1;
            end
            DONE: begin
               bcd_out <= scratch;
               done    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // busy also covers the done cycle so that it spans WIDTH+2 cycles, matching
   // the conversion period; under a held start the next SHIFT follows directly.
   assign busy = (state != IDLE) | done;

`ifdef BIN_TO_BCD_LEADING_ZERO_BLANK_EN
   localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

   logic [DIGITS-1:0] blank_nxt;
   logic              hi_zero;

   // Walk from the most significant digit down, accumulating "all zero so far".
   always_comb begin
      blank_nxt = '0;
      hi_zero   = 1'b1;
      for (int unsigned i = DIGITS - 1; i > 0; i--) begin
         hi_zero      = hi_zero & (scratch[DIGIT_W*i +: DIGIT_W] == '0);
         blank_nxt[i] = hi_zero;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blank <= BLANK_RST;
      end else if (state == DONE) begin
         blank <= blank_nxt;
      end
   end
`else
   assign blank = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd.sv
module tb_bin_to_bcd;

   localparam int unsigned WIDTH  = 16;
   localparam int unsigned DIGITS = 5;

`ifdef BIN_TO_BCD_LEADING_ZERO_BLANK_EN
   localparam logic [4:0] BLANK_RST = 5'b11110;
   localparam logic [4:0] BL_0      = 5'b11110;
   localparam logic [4:0] BL_65535  = 5'b00000;
   localparam logic [4:0] BL_1234   = 5'b10000;
   localparam logic [4:0] BL_9      = 5'b11110;
   localparam logic [4:0] BL_4321   = 5'b10000;
   localparam logic [4:0] BL_999    = 5'b11000;
`else
   localparam logic [4:0] BLANK_RST = 5'b00000;
   localparam logic [4:0] BL_0      = 5'b00000;
   localparam logic [4:0] BL_65535  = 5'b00000;
   localparam logic [4:0] BL_1234   = 5'b00000;
   localparam logic [4:0] BL_9      = 5'b00000;
   localparam logic [4:0] BL_4321   = 5'b00000;
   localparam logic [4:0] BL_999    = 5'b00000;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] bin_in = '0;
   logic        busy;
   logic        done;
   logic [19:0] bcd_out;
   logic [4:0]  blank;

   int n_tests = 0;
   int n_fail  = 0;

   bin_to_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .bin_in  (bin_in),
      .busy    (busy),
      .done    (done),
      .bcd_out (bcd_out),
      .blank   (blank)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------- reference
   function automatic logic [19:0] dec(input int unsigned v);
      logic [19:0] r;
      int unsigned p;
      r = '0;
      p = 1;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   function automatic logic [4:0] blk(input int unsigned v);
      logic [4:0] r;
      int unsigned p;
      r = '0;
      p = 1;
      for (int i = 1; i < 5; i++) begin
         p = p * 10;
`ifdef BIN_TO_BCD_LEADING_ZERO_BLANK_EN
         r[i] = (v < p);
`endif
      end
      return r;
   endfunction

   // Cycle-level view: a conversion occupies WIDTH+1 edges after acceptance,
   // the result appears on the last of them, then one idle-capable edge.
   int unsigned m_rem = 0;
   int unsigned m_val = 0;
   logic [19:0] m_bcd = '0;
   logic [4:0]  m_blank = BLANK_RST;
   logic        m_done = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_rem   = 0;
         m_val   = 0;
         m_bcd   = '0;
         m_blank = BLANK_RST;
         m_done  = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_rem == 0) begin
            if (start) begin
               m_val = bin_in;
               m_rem = WIDTH + 1;
            end
         end else begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
               m_bcd   = dec(m_val);
               m_blank = blk(m_val);
               m_done  = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic exp_busy;
      exp_busy = (m_rem != 0) || m_done;
      n_tests++;
      if (bcd_out !== m_bcd || blank !== m_blank || done !== m_done || busy !== exp_busy) begin
         n_fail++;
         $display("FAIL model_cycle t=%0t: got bcd=%h blank=%b done=%b busy=%b, expected bcd=%h blank=%b done=%b busy=%b",
                  $time, bcd_out, blank, done, busy, m_bcd, m_blank, m_done, exp_busy);
      end
   end

   // ------------------------------------------------------------ helpers
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Start one conversion and wait for its done pulse (bounded).
   task automatic run_conv(input logic [15:0] v, input logic [19:0] eb,
                           input logic [4:0] ebl, input string name);
      int lat;
      int busyc;
      @(negedge clk);
      start  = 1'b1;
      bin_in = v;
      @(posedge clk);
      #1;
      start  = 1'b0;
      bin_in = 16'($urandom);
      lat    = 0;
      busyc  = busy ? 1 : 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (busy) busyc++;
         if (done) begin
            lat = c;
            break;
         end
      end
      chk({name, "_latency"}, lat, 17);
      chk({name, "_busy_cycles"}, busyc, 18);
      chk({name, "_bcd"}, {12'd0, bcd_out}, {12'd0, eb});
      chk({name, "_blank"}, {27'd0, blank}, {27'd0, ebl});
      @(posedge clk);
      #1;
      chk({name, "_done_pulse_width"}, {31'd0, done}, 32'd0);
      chk({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
   endtask

   // ------------------------------------------------------------ stimulus
   initial begin
      int lat;
      int ndone;
      int unsigned v;
      int unsigned val;
      int unsigned p;
      logic [3:0] d;
      bit ok;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_bcd", {12'd0, bcd_out}, 32'd0);
      chk("reset_blank", {27'd0, blank}, {27'd0, BLANK_RST});
      @(negedge clk);
      rst = 1'b0;

      run_conv(16'd0, 20'h00000, BL_0, "zero");
      run_conv(16'd65535, 20'h65535, BL_65535, "max");

      // Back-to-back with start held high.
      @(negedge clk);
      start  = 1'b1;
      bin_in = 16'd1234;
      @(posedge clk);
      #1;
      bin_in = 16'($urandom);
      lat = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (done) begin lat = c; break; end
      end
      chk("b2b_first_latency", lat, 17);
      chk("b2b_first_bcd", {12'd0, bcd_out}, 32'h01234);
      chk("b2b_first_blank", {27'd0, blank}, {27'd0, BL_1234});
      bin_in = 16'd9;
      @(posedge clk);
      #1;
      chk("b2b_second_accepted", {31'd0, busy}, 32'd1);
      start = 1'b0;
      lat = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (done) begin lat = c; break; end
      end
      chk("b2b_second_latency", lat, 17);
      chk("b2b_second_bcd", {12'd0, bcd_out}, 32'h00009);
      chk("b2b_second_blank", {27'd0, blank}, {27'd0, BL_9});

      // Start pulse while busy must be ignored.
      @(negedge clk);
      start  = 1'b1;
      bin_in = 16'd4321;
      @(posedge clk);
      #1;
      start = 1'b0;
      ndone = 0;
      lat   = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (c == 3) begin
            start  = 1'b1;
            bin_in = 16'd100;
         end else if (c == 4) begin
            start = 1'b0;
         end
         if (done) begin
            ndone++;
            if (lat == 0) lat = c;
         end
      end
      chk("busy_start_done_count", ndone, 1);
      chk("busy_start_latency", lat, 17);
      chk("busy_start_bcd", {12'd0, bcd_out}, 32'h04321);
      chk("busy_start_blank", {27'd0, blank}, {27'd0, BL_4321});

      // Reset in the middle of a conversion of 999.
      @(negedge clk);
      start  = 1'b1;
      bin_in = 16'd999;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      chk("midrst_bcd", {12'd0, bcd_out}, 32'd0);
      chk("midrst_blank", {27'd0, blank}, {27'd0, BLANK_RST});
      ndone = 0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
      end
      chk("midrst_no_done", ndone, 0);
      run_conv(16'd999, 20'h00999, BL_999, "after_rst");

      // Random sweep.
      for (int n = 0; n < 2000; n++) begin
         v = $urandom_range(0, 65535);
         run_conv(16'(v), dec(v), blk(v), "rand");
         ok  = 1'b1;
         val = 0;
         p   = 1;
         for (int i = 0; i < 5; i++) begin
            d = bcd_out[4*i +: 4];
            if (d > 4'd9) ok = 1'b0;
            val = val + d * p;
            p = p * 10;
         end
         chk("rand_digit_range", {31'd0, ok}, 32'd1);
         chk("rand_decimal_value", val, v);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
